// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-style decode slice.
//   - default datapath / register-index widths
//   - opcode constants and the ranges that write the rt field
//   - decode-slot FSM state type
//   - dst_sel(): maps an opcode to the instruction field naming the destination
package mips_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_ITYPE_LO = 6'h08;
  localparam logic [5:0] OP_ITYPE_HI = 6'h0F;
  localparam logic [5:0] OP_LOAD_LO  = 6'h20;
  localparam logic [5:0] OP_LOAD_HI  = 6'h25;

  // Decode slot occupancy: EMPTY, holding and free to go, holding and stalled
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_STALL = 2'd2
  } id_state_t;

  // Which field names the written register
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2,
    DST_RA   = 2'd3
  } dst_sel_t;

  function automatic dst_sel_t dst_sel(input logic [5:0] opcode);
    dst_sel_t sel;
    if (opcode == OP_RTYPE) begin
      sel = DST_RD;
    end else if ((opcode >= OP_ITYPE_LO && opcode <= OP_ITYPE_HI) ||
                 (opcode >= OP_LOAD_LO  && opcode <= OP_LOAD_HI)) begin
      sel = DST_RT;
    end else if (opcode == OP_JAL) begin
      sel = DST_RA;
    end else begin
      sel = DST_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/decode_hazard.sv
// decode_hazard: operand source selection and stall detection for the
// instruction held in decode. Purely combinational.
//   ra1/ra2        : register indices read by the instruction (rs, rt)
//   rd1/rd2        : register-file data for ra1/ra2
//   exf_* / memf_* : destination info of the instructions in EX and MEM
//   op_a/op_b      : selected rs/rt operands
//   hazard         : decode must hold this cycle
// Macro DECODE_FWD_EN: when defined, EX/MEM results are forwarded and only a
// load in EX feeding decode stalls; otherwise operands come straight from the
// register file and any pending EX/MEM write to a read register stalls.
module decode_hazard
  import mips_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          exf_we,
  input  logic [AW-1:0] exf_wa,
  input  logic          exf_load,
  input  logic [DW-1:0] exf_wd,
  input  logic          memf_we,
  input  logic [AW-1:0] memf_wa,
  input  logic [DW-1:0] memf_wd,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic          hazard
);

`ifdef DECODE_FWD_EN
  // Register 0 reads as zero; the younger EX result wins over MEM
  function automatic logic [DW-1:0] pick(input logic [AW-1:0] idx, input logic [DW-1:0] rf);
    logic [DW-1:0] v;
    if (idx == {AW{1'b0}}) begin
      v = {DW{1'b0}};
    end else if (exf_we && !exf_load && (exf_wa == idx)) begin
      v = exf_wd;
    end else if (memf_we && (memf_wa == idx)) begin
      v = memf_wd;
    end else begin
      v = rf;
    end
    return v;
  endfunction

  // Forwarded operands; a load result is not available until after MEM
  always_comb begin
    op_a   = pick(ra1, rd1);
    op_b   = pick(ra2, rd2);
    hazard = exf_we && exf_load && (exf_wa != {AW{1'b0}}) &&
             ((exf_wa == ra1) || (exf_wa == ra2));
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{exf_load, exf_wd, memf_wd};

  // No bypass: wait until every pending writer of a read register retires
  always_comb begin
    op_a   = rd1;
    op_b   = rd2;
    hazard = (exf_we && (exf_wa != {AW{1'b0}}) &&
              ((exf_wa == ra1) || (exf_wa == ra2))) ||
             (memf_we && (memf_wa != {AW{1'b0}}) &&
              ((memf_wa == ra1) || (memf_wa == ra2)));
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-slot instruction decode stage with valid/ready handshakes.
//   if_valid/if_instr/if_pc/id_ready : fetch handshake into the decode slot
//   flush                           : kill slot and EX-output contents next edge
//   ra1/ra2, rd1/rd2                : register-file read port (async data)
//   exf_*/memf_*                    : EX/MEM destination info for bypass/stall
//   ex_valid/ex_ready, ex_*         : registered handshake into EX
// Macro DECODE_FWD_EN selects forwarding (see decode_hazard).
module decode_stage
  import mips_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  output logic          id_ready,
  input  logic          flush,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          exf_we,
  input  logic [AW-1:0] exf_wa,
  input  logic          exf_load,
  input  logic [DW-1:0] exf_wd,
  input  logic          memf_we,
  input  logic [AW-1:0] memf_wa,
  input  logic [DW-1:0] memf_wd,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] ex_instr,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_op_a,
  output logic [DW-1:0] ex_op_b,
  output logic [AW-1:0] ex_wa
);

  id_state_t     state_r;
  id_state_t     state_nxt_s;
  logic [DW-1:0] id_instr_r;
  logic [DW-1:0] id_pc_r;
  logic          id_vld_s;
  logic          accept_s;
  logic          advance_s;
  logic          hazard_s;
  logic [DW-1:0] op_a_s;
  logic [DW-1:0] op_b_s;
  logic [AW-1:0] wa_s;

  assign id_vld_s  = (state_r != ST_EMPTY);
  assign advance_s = id_vld_s && !hazard_s && (!ex_valid || ex_ready);
  assign id_ready  = !id_vld_s || advance_s;

  // Register read indices come from the held instruction; idle port reads r0
  always_comb begin
    if (id_vld_s) begin
      ra1 = AW'(id_instr_r[25:21]);
      ra2 = AW'(id_instr_r[20:16]);
    end else begin
      ra1 = {AW{1'b0}};
      ra2 = {AW{1'b0}};
    end
  end

  // Destination register decode
  always_comb begin
    case (dst_sel(id_instr_r[31:26]))
      DST_RD:  wa_s = AW'(id_instr_r[15:11]);
      DST_RT:  wa_s = AW'(id_instr_r[20:16]);
      DST_RA:  wa_s = AW'(5'd31);
      default: wa_s = {AW{1'b0}};
    endcase
  end

  decode_hazard #(.DW(DW), .AW(AW)) u_hazard (
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .exf_we   (exf_we),
    .exf_wa   (exf_wa),
    .exf_load (exf_load),
    .exf_wd   (exf_wd),
    .memf_we  (memf_we),
    .memf_wa  (memf_wa),
    .memf_wd  (memf_wd),
    .op_a     (op_a_s),
    .op_b     (op_b_s),
    .hazard   (hazard_s)
  );

  // Slot FSM next state; flush wins and drops whatever fetch offers
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (if_valid && !flush) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_READY, ST_STALL: begin
        if (flush) begin
          state_nxt_s = ST_EMPTY;
        end else if (advance_s && if_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_READY;
        end else if (advance_s) begin
          state_nxt_s = ST_EMPTY;
        end else if (hazard_s) begin
          state_nxt_s = ST_STALL;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Slot FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Decode slot contents, captured on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr_r <= {DW{1'b0}};
      id_pc_r    <= {DW{1'b0}};
    end else if (accept_s) begin
      id_instr_r <= if_instr;
      id_pc_r    <= if_pc;
    end
  end

  // EX-side output registers; payload holds while EX back-pressures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_instr <= {DW{1'b0}};
      ex_pc    <= {DW{1'b0}};
      ex_op_a  <= {DW{1'b0}};
      ex_op_b  <= {DW{1'b0}};
      ex_wa    <= {AW{1'b0}};
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance_s) begin
      ex_valid <= 1'b1;
      ex_instr <= id_instr_r;
      ex_pc    <= id_pc_r;
      ex_op_a  <= op_a_s;
      ex_op_b  <= op_b_s;
      ex_wa    <= wa_s;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Expectations are pushed
// when fetch hands an instruction over and compared when EX takes it.
module tb_decode_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_valid, id_ready, flush;
  logic [DW-1:0] if_instr, if_pc, rd1, rd2;
  logic [AW-1:0] ra1, ra2;
  logic          exf_we, exf_load, memf_we;
  logic [AW-1:0] exf_wa, memf_wa, ex_wa;
  logic [DW-1:0] exf_wd, memf_wd;
  logic          ex_valid, ex_ready;
  logic [DW-1:0] ex_instr, ex_pc, ex_op_a, ex_op_b;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  wa;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] pc_n       = 32'h0000_0400;

  always #5 clk = ~clk;

  decode_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .exf_we(exf_we), .exf_wa(exf_wa), .exf_load(exf_load), .exf_wd(exf_wd),
    .memf_we(memf_we), .memf_wa(memf_wa), .memf_wd(memf_wd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_wa(ex_wa)
  );

  // Register file model: r0 reads zero, rN reads 0x1000+N
  function automatic logic [31:0] regv(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : (32'h0000_1000 + {27'd0, idx});
  endfunction

  assign rd1 = regv(ra1);
  assign rd2 = regv(ra2);

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h21};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Scoreboard: compare every instruction EX takes
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (sb_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_ex got_instr=%h required=no instruction", ex_instr);
      end else begin
        mon_e = sb_q.pop_front();
        compared++;
        if (ex_instr !== mon_e.instr) begin mismatched++; $display("FAIL ex_instr got=%h exp=%h", ex_instr, mon_e.instr); end
        compared++;
        if (ex_pc !== mon_e.pc) begin mismatched++; $display("FAIL ex_pc got=%h exp=%h", ex_pc, mon_e.pc); end
        compared++;
        if (ex_op_a !== mon_e.op_a) begin mismatched++; $display("FAIL ex_op_a instr=%h got=%h exp=%h", mon_e.instr, ex_op_a, mon_e.op_a); end
        compared++;
        if (ex_op_b !== mon_e.op_b) begin mismatched++; $display("FAIL ex_op_b instr=%h got=%h exp=%h", mon_e.instr, ex_op_b, mon_e.op_b); end
        compared++;
        if (ex_wa !== mon_e.wa) begin mismatched++; $display("FAIL ex_wa instr=%h got=%0d exp=%0d", mon_e.instr, ex_wa, mon_e.wa); end
      end
    end
  end

  // Offer one instruction until accepted, then record its expected EX payload
  task automatic send_x(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    if_instr = instr; if_pc = pc_n; if_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = id_ready;
      @(posedge clk); #1;
    end
    if_valid = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL accept_timeout instr=%h got id_ready=0 exp=1", instr);
    end else begin
      e.instr = instr; e.pc = pc_n; e.op_a = a; e.op_b = b; e.wa = wa;
      sb_q.push_back(e);
    end
    pc_n += 32'd4;
  endtask

  task automatic send(input logic [31:0] instr, input logic [4:0] wa);
    send_x(instr, regv(instr[25:21]), regv(instr[20:16]), wa);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout got pending=%0d exp=0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_fwd;
    exf_we = 1'b0; exf_load = 1'b0; exf_wa = 5'd0; exf_wd = 32'd0;
    memf_we = 1'b0; memf_wa = 5'd0; memf_wd = 32'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; flush = 1'b0; ex_ready = 1'b1;
    clear_fwd();
    #1 rst_n = 1'b0;
    #1;
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); end
    compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL rst_id_ready got=%b exp=1", id_ready); end
    compared++; if (ra1 !== 5'd0) begin mismatched++; $display("FAIL rst_ra1 got=%0d exp=0", ra1); end
    compared++; if (ra2 !== 5'd0) begin mismatched++; $display("FAIL rst_ra2 got=%0d exp=0", ra2); end
    compared++; if ({ex_instr, ex_pc, ex_op_a, ex_op_b} !== 128'd0) begin mismatched++; $display("FAIL rst_ex_data got=%h exp=0", {ex_instr, ex_pc, ex_op_a, ex_op_b}); end
    compared++; if (ex_wa !== 5'd0) begin mismatched++; $display("FAIL rst_ex_wa got=%0d exp=0", ex_wa); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_decode;
    logic [31:0] prog [12];
    logic [4:0]  wa   [12];
    prog[0]  = rtype(5'd1, 5'd2, 5'd3);                 wa[0]  = 5'd3;
    prog[1]  = itype(6'h23, 5'd5, 5'd4, 16'h0010);      wa[1]  = 5'd4;
    prog[2]  = {6'h03, 26'h000_0040};                   wa[2]  = 5'd31;
    prog[3]  = itype(6'h04, 5'd6, 5'd7, 16'h0002);      wa[3]  = 5'd0;
    prog[4]  = itype(6'h08, 5'd8, 5'd9, 16'h0005);      wa[4]  = 5'd9;
    prog[5]  = itype(6'h0F, 5'd0, 5'd17, 16'h1234);     wa[5]  = 5'd17;
    prog[6]  = itype(6'h2B, 5'd10, 5'd11, 16'h0000);    wa[6]  = 5'd0;
    prog[7]  = itype(6'h25, 5'd12, 5'd13, 16'h0000);    wa[7]  = 5'd13;
    prog[8]  = itype(6'h26, 5'd14, 5'd15, 16'h0000);    wa[8]  = 5'd0;
    prog[9]  = itype(6'h20, 5'd18, 5'd20, 16'h0004);    wa[9]  = 5'd20;
    prog[10] = itype(6'h07, 5'd21, 5'd22, 16'h0000);    wa[10] = 5'd0;
    prog[11] = itype(6'h10, 5'd23, 5'd24, 16'h0000);    wa[11] = 5'd0;
    ex_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(prog[i], wa[i]);
    drain();
  endtask

  task automatic test_forward;
    logic [31:0] ea, eb;
    for (int k = 0; k < 3; k++) begin
      clear_fwd();
      case (k)
        0: begin exf_we = 1'b1; exf_wa = 5'd1; exf_wd = 32'h55; end
        1: begin memf_we = 1'b1; memf_wa = 5'd1; memf_wd = 32'h66; end
        default: begin exf_we = 1'b1; exf_wa = 5'd2; exf_wd = 32'h77;
                       memf_we = 1'b1; memf_wa = 5'd2; memf_wd = 32'h88; end
      endcase
`ifdef DECODE_FWD_EN
      ea = (k == 0) ? 32'h55 : ((k == 1) ? 32'h66 : regv(5'd1));
      eb = (k == 2) ? 32'h77 : regv(5'd2);
      send_x(rtype(5'd1, 5'd2, 5'd3), ea, eb, 5'd3);
      drain();
      clear_fwd();
`else
      ea = regv(5'd1);
      eb = regv(5'd2);
      send_x(rtype(5'd1, 5'd2, 5'd3), ea, eb, 5'd3);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL nofwd_stall_ready k=%0d got=%b exp=0", k, id_ready); end
        compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL nofwd_stall_valid k=%0d got=%b exp=0", k, ex_valid); end
        @(posedge clk); #1;
      end
      clear_fwd();
      drain();
`endif
    end
  endtask

  task automatic test_reg0;
    clear_fwd();
    exf_we = 1'b1; exf_wa = 5'd0; exf_wd = 32'hFF;
    memf_we = 1'b1; memf_wa = 5'd0; memf_wd = 32'hEE;
    send_x(rtype(5'd0, 5'd2, 5'd3), 32'd0, regv(5'd2), 5'd3);
    drain();
    clear_fwd();
  endtask

  task automatic test_load_use;
    for (int k = 0; k < 2; k++) begin
      clear_fwd();
      exf_we = 1'b1; exf_load = 1'b1; exf_wa = 5'd4; exf_wd = 32'hDEAD;
      if (k == 0) send(rtype(5'd4, 5'd1, 5'd5), 5'd5);
      else        send(rtype(5'd1, 5'd4, 5'd5), 5'd5);
      @(negedge clk);
      compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL lu_stall_ready k=%0d got=%b exp=0", k, id_ready); end
      compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL lu_stall_valid k=%0d got=%b exp=0", k, ex_valid); end
      @(posedge clk); #1;
      clear_fwd();
      @(negedge clk);
      compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL lu_release_ready k=%0d got=%b exp=1", k, id_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      compared++; if (ex_valid !== 1'b1) begin mismatched++; $display("FAIL lu_advance_valid k=%0d got=%b exp=1", k, ex_valid); end
      drain();
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a, b, pa;
    a = rtype(5'd6, 5'd7, 5'd8);
    b = itype(6'h09, 5'd1, 5'd2, 16'h0007);
    ex_ready = 1'b0;
    pa = pc_n;
    send(a, 5'd8);
    send(b, 5'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++; if (ex_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, ex_valid); end
      compared++; if (ex_instr !== a) begin mismatched++; $display("FAIL bp_instr c=%0d got=%h exp=%h", c, ex_instr, a); end
      compared++; if (ex_pc !== pa) begin mismatched++; $display("FAIL bp_pc c=%0d got=%h exp=%h", c, ex_pc, pa); end
      compared++; if (ex_op_a !== regv(5'd6)) begin mismatched++; $display("FAIL bp_op_a c=%0d got=%h exp=%h", c, ex_op_a, regv(5'd6)); end
      compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL bp_id_ready c=%0d got=%b exp=0", c, id_ready); end
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back;
    bit done;
    logic [4:0] rs, rt, rd;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
          send(rtype(rs, rt, rd), rd);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ex_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ex_ready = 1'b1;
    drain();
  endtask

  task automatic test_flush;
    ex_ready = 1'b0;
    send(rtype(5'd1, 5'd2, 5'd3), 5'd3);
    send(rtype(5'd4, 5'd5, 5'd6), 5'd6);
    if_instr = rtype(5'd7, 5'd8, 5'd9); if_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL flush_ex_valid got=%b exp=0", ex_valid); end
    compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL flush_id_ready got=%b exp=1", id_ready); end
    compared++; if (ra1 !== 5'd0) begin mismatched++; $display("FAIL flush_ra1 got=%0d exp=0", ra1); end
    @(posedge clk); #1;
    // Flush while the slot is empty must also drop the offered instruction
    ex_ready = 1'b1;
    if_instr = rtype(5'd10, 5'd11, 5'd12); if_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL flush_drop_valid c=%0d got=%b exp=0", c, ex_valid); end
      compared++; if (ra1 !== 5'd0) begin mismatched++; $display("FAIL flush_drop_ra1 c=%0d got=%0d exp=0", c, ra1); end
      @(posedge clk); #1;
    end
    send(rtype(5'd13, 5'd14, 5'd15), 5'd15);
    drain();
  endtask

  task automatic test_reset_midstall;
    ex_ready = 1'b0;
    clear_fwd();
    exf_we = 1'b1; exf_load = 1'b1; exf_wa = 5'd4;
    send(rtype(5'd1, 5'd2, 5'd3), 5'd3);
    send(rtype(5'd4, 5'd2, 5'd6), 5'd6);
    @(negedge clk);
    compared++; if (ra1 !== 5'd4) begin mismatched++; $display("FAIL ms_ra1_before got=%0d exp=4", ra1); end
    compared++; if (id_ready !== 1'b0) begin mismatched++; $display("FAIL ms_ready_before got=%b exp=0", id_ready); end
    compared++; if (ex_valid !== 1'b1) begin mismatched++; $display("FAIL ms_valid_before got=%b exp=1", ex_valid); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL ms_rst_valid got=%b exp=0", ex_valid); end
    compared++; if (id_ready !== 1'b1) begin mismatched++; $display("FAIL ms_rst_ready got=%b exp=1", id_ready); end
    compared++; if (ra1 !== 5'd0) begin mismatched++; $display("FAIL ms_rst_ra1 got=%0d exp=0", ra1); end
    compared++; if (ex_instr !== 32'd0) begin mismatched++; $display("FAIL ms_rst_instr got=%h exp=0", ex_instr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_fwd();
    ex_ready = 1'b1;
    send(rtype(5'd9, 5'd10, 5'd11), 5'd11);
    drain();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_forward();
    test_reg0();
    test_load_use();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midstall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width.
REQ-002 SHALL have parameter AW, default 5, register-index width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_valid  in  1  fetch presents an instruction.
REQ-006 SHALL have port if_instr  in  DW  fetched instruction word.
REQ-007 SHALL have port if_pc  in  DW  PC of if_instr.
REQ-008 SHALL have port id_ready  out  1  stage accepts if_* this cycle.
REQ-009 SHALL have port flush  in  1  branch/jump redirect; kill in-flight work.
REQ-010 SHALL have port ra1  out  AW  register-file read address 1 (rs).
REQ-011 SHALL have port ra2  out  AW  register-file read address 2 (rt).
REQ-012 SHALL have port rd1  in  DW  asynchronous read data for ra1.
REQ-013 SHALL have port rd2  in  DW  asynchronous read data for ra2.
REQ-014 SHALL have port exf_we  in  1  EX-stage instruction writes a register.
REQ-015 SHALL have port exf_wa  in  AW  EX-stage destination.
REQ-016 SHALL have port exf_load  in  1  EX-stage instruction is a load.
REQ-017 SHALL have port exf_wd  in  DW  EX-stage result.
REQ-018 SHALL have port memf_we  in  1  MEM-stage instruction writes a register.
REQ-019 SHALL have port memf_wa  in  AW  MEM-stage destination.
REQ-020 SHALL have port memf_wd  in  DW  MEM-stage result.
REQ-021 SHALL have port ex_valid  out  1  ex_* outputs hold a valid instruction.
REQ-022 SHALL have port ex_ready  in  1  EX consumes ex_* this cycle.
REQ-023 SHALL have ports ex_instr, ex_pc, ex_op_a, ex_op_b  out  DW each  registered instruction, PC, rs operand, rt operand.
REQ-024 SHALL have port ex_wa  out  AW  decoded destination; 0 means no write.

Function
REQ-025 SHALL hold one instruction slot (id_vld, id_instr, id_pc); FSM states EMPTY (id_vld=0), READY (valid, no hazard), STALL (valid, hazard).
REQ-026 SHALL drive ra1=id_instr[25:21], ra2=id_instr[20:16] combinationally; drive 0 when EMPTY.
REQ-027 SHALL decode ex_wa: opcode 0 -> [15:11]; opcodes 0x08-0x0F and 0x20-0x25 -> [20:16]; JAL (0x03) -> 31; all others -> 0.
REQ-028 SHALL select each operand by priority: index 0 -> 0; EX match (exf_we, !exf_load, exf_wa==index) -> exf_wd; MEM match -> memf_wd; else rd1/rd2.
REQ-029 SHALL flag hazard when exf_we && exf_load && exf_wa!=0 && exf_wa equals ra1 or ra2 (both treated as used).
REQ-030 SHALL advance (load ex_* registers, set ex_valid) when id_vld && !hazard && (!ex_valid || ex_ready).
REQ-031 SHALL clear ex_valid when ex_ready and no advance; ex_* SHALL hold stable while ex_valid && !ex_ready.
REQ-032 SHALL assert id_ready = !id_vld || advance; accepted instruction reaches ex_valid one edge later at minimum.
REQ-033 SHALL on flush clear id_vld and ex_valid at the next edge, overriding advance and ignoring if_valid that cycle.

Reset
REQ-034 SHALL on rst_n low immediately force EMPTY, ex_valid=0, ex_instr/ex_pc/ex_op_a/ex_op_b=0, ex_wa=0, independent of clk; id_ready=1 while EMPTY.

Configuration
REQ-035 SHALL with DECODE_FWD_EN defined implement REQ-028/REQ-029; without it, take operands from rd1/rd2 only and flag hazard on any nonzero EX or MEM destination match (load or not).

Structure
REQ-036 SHALL take opcode constants, AW/DW defaults and the FSM state type from shared package mips_pkg.
REQ-037 SHALL place match/forward/hazard logic in sub-module decode_hazard.

Verification
REQ-038 Reset: rst_n low mid-stall -> ex_valid=0, id_ready=1, ra1=0 asynchronously.
REQ-039 Forward: addu $3,$1,$2 in ID, exf_we=1 exf_wa=1 exf_wd=0x55, rd1=0x11 -> ex_op_a=0x55; same with only memf match wd=0x66 -> 0x66.
REQ-040 Load-use: lw $4 in EX (exf_load=1, exf_wa=4), ID reads $4 -> id_ready=0 one cycle, ex_valid=0, then advances.
REQ-041 Register 0: ra1=0, exf_we=1 exf_wa=0 exf_wd=0xFF -> ex_op_a=0.
REQ-042 Backpressure: ex_ready=0 three cycles -> ex_* unchanged, id_ready=0 with slot full; ex_ready=1 -> next instruction loads.
REQ-043 Flush: flush=1 while id_vld and ex_valid and if_valid -> next cycle ex_valid=0, slot EMPTY, if_instr dropped.
